// File: rtl/percept_pkg.sv
// Shared definitions for the perceptron chain serial link: default field widths,
// frame width helper, opcodes understood by percept_control, and the tx FSM states.
package percept_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int OP_W_DEF   = 3;
  localparam int DATA_W_DEF = 62;

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_WR_WGT  = 3'd1;
  localparam logic [2:0] OP_WR_BIAS = 3'd2;
  localparam logic [2:0] OP_RD_WGT  = 3'd3;
  localparam logic [2:0] OP_FIRE    = 3'd4;
  localparam logic [2:0] OP_LEARN   = 3'd5;
  localparam logic [2:0] OP_CLEAR   = 3'd6;
  localparam logic [2:0] OP_BCAST   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } tx_state_e;

  // Start bit plus address, opcode and data fields.
  function automatic int frame_w(input int addr_w, input int op_w, input int data_w);
    return 1 + addr_w + op_w + data_w;
  endfunction

endpackage

// File: rtl/percept_frame_tx.sv
// Serialiser feeding the percept_control rx line: one command per handshake,
// start bit then address/opcode/data MSB first, followed by GAP idle-high bits.
//
// state    | meaning
// ST_IDLE  | line high; loads the held command into the shifter when one is queued
// ST_SHIFT | start bit and payload bits on tx, one per clock
// ST_GAP   | line held high for GAP clocks, frame counted on exit
module percept_frame_tx
  import percept_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int OP_W   = OP_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int GAP    = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_address,
  input  logic [OP_W-1:0]   in_opcode,
  input  logic [DATA_W-1:0] in_data,
  output logic              tx,
  output logic              busy,
  output logic [CNT_W-1:0]  frames_sent
);

  localparam int FRAME_W = frame_w(ADDR_W, OP_W, DATA_W);
  localparam int BC_W    = $clog2(FRAME_W);
  localparam int GC_W    = $clog2(GAP + 1);

  generate
    if (GAP < 1) begin : g_gap_chk
      $error("percept_frame_tx: GAP must be at least 1");
    end
  endgenerate

  tx_state_e            state_q, state_d;
  logic                 hold_full_q, hold_full_d;
  logic [FRAME_W-2:0]   hold_q, hold_d;
  logic [FRAME_W-1:0]   shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic [BC_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [GC_W-1:0]      gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0]     frames_q, frames_d;
  logic                 accept;
  logic                 load;

  // Ready comes from registered state only; rst masks it so nothing is taken while held in reset.
  assign in_ready    = ~hold_full_q & ~rst;
  assign accept      = in_valid & in_ready;
  assign load        = (state_q == ST_IDLE) & hold_full_q;

  assign tx          = tx_q;
  assign busy        = (state_q != ST_IDLE) | hold_full_q;
  assign frames_sent = frames_q;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    tx_d        = 1'b1;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    frames_d    = frames_q;
    hold_d      = hold_q;
    hold_full_d = (hold_full_q & ~load) | accept;

    if (accept) begin
      hold_d = {in_address, in_opcode, in_data};
    end

    case (state_q)
      ST_IDLE: begin
        if (hold_full_q) begin
          shift_d   = {1'b0, hold_q};
          tx_d      = 1'b0;
          bit_cnt_d = BC_W'(FRAME_W - 1);
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bit_cnt_q != '0) begin
          shift_d   = shift_q << 1;
          tx_d      = shift_q[FRAME_W-2];
          bit_cnt_d = bit_cnt_q - 1'b1;
        end else begin
          gap_cnt_d = GC_W'(GAP - 1);
          state_d   = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == '0) begin
          frames_d = frames_q + 1'b1;
          state_d  = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hold_full_q <= 1'b0;
      hold_q      <= '0;
      shift_q     <= '0;
      tx_q        <= 1'b1;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      frames_q    <= '0;
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      hold_q      <= hold_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      frames_q    <= frames_d;
    end
  end

endmodule

// File: tb/tb_percept_frame_tx.sv
// Bench for percept_frame_tx: a timeline model predicts tx, busy, in_ready and the frame
// count for every cycle from accept times and frame length; a CNT_W=2 copy checks wrap.
module tb_percept_frame_tx;

  localparam int AW   = 8;
  localparam int OW   = 3;
  localparam int DW   = 62;
  localparam int FW   = 1 + AW + OW + DW;
  localparam int GP   = 2;
  localparam int MAXC = 4096;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [AW-1:0] in_address = '0;
  logic [OW-1:0] in_opcode = '0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, tx, busy;
  logic [15:0]   frames_sent;
  logic          in_ready2, tx2, busy2;
  logic [1:0]    frames_sent2;

  percept_frame_tx #(.ADDR_W(AW), .OP_W(OW), .DATA_W(DW), .GAP(GP), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_address(in_address), .in_opcode(in_opcode), .in_data(in_data),
    .tx(tx), .busy(busy), .frames_sent(frames_sent));

  percept_frame_tx #(.ADDR_W(AW), .OP_W(OW), .DATA_W(DW), .GAP(GP), .CNT_W(2)) dut_w2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_address(in_address), .in_opcode(in_opcode), .in_data(in_data),
    .tx(tx2), .busy(busy2), .frames_sent(frames_sent2));

  always #5 clk = ~clk;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int fr_exp = 0;
  int next_free = 0;
  int last_s = 0;
  bit checking = 1'b0;
  bit exp_tx   [MAXC];
  bit exp_busy [MAXC];
  bit exp_hold [MAXC];
  bit exp_inc  [MAXC];

  task automatic model_reset(input int r);
    for (int c = r; c < MAXC; c++) begin
      exp_tx[c] = 1'b1; exp_busy[c] = 1'b0; exp_hold[c] = 1'b0; exp_inc[c] = 1'b0;
    end
    next_free = 0;
  endtask

  // Command accepted at edge k: it goes on the wire at the first free load edge.
  task automatic model_accept(input int k, input logic [AW-1:0] a,
                              input logic [OW-1:0] o, input logic [DW-1:0] d);
    logic [FW-1:0] fr;
    int s;
    fr = {1'b0, a, o, d};
    s = (k + 1 > next_free) ? k + 1 : next_free;
    if (s + FW + GP + 4 >= MAXC) begin
      $display("FAIL timeline_overflow cycle %0d", s);
      $fatal(1, "timeline overflow");
    end
    for (int c = k; c < s; c++) exp_hold[c] = 1'b1;
    for (int c = k; c < s + FW + GP; c++) exp_busy[c] = 1'b1;
    for (int i = 0; i < FW; i++) exp_tx[s + i] = fr[FW-1-i];
    exp_inc[s + FW + GP] = 1'b1;
    next_free = s + FW + GP + 1;
    last_s = s;
  endtask

  task automatic check(input int c);
    logic exp_rdy;
    exp_rdy = ~rst & ~exp_hold[c];
    vectors++;
    assert (tx === exp_tx[c]) else begin
      miscompares++;
      $error("FAIL tx cyc=%0d observed=%b expected=%b", c, tx, exp_tx[c]);
    end
    vectors++;
    assert (busy === exp_busy[c]) else begin
      miscompares++;
      $error("FAIL busy cyc=%0d observed=%b expected=%b", c, busy, exp_busy[c]);
    end
    vectors++;
    assert (in_ready === exp_rdy) else begin
      miscompares++;
      $error("FAIL in_ready cyc=%0d observed=%b expected=%b", c, in_ready, exp_rdy);
    end
    vectors++;
    assert (frames_sent === 16'(fr_exp)) else begin
      miscompares++;
      $error("FAIL frames_sent cyc=%0d observed=%0d expected=%0d", c, frames_sent, 16'(fr_exp));
    end
    vectors++;
    assert (frames_sent2 === 2'(fr_exp)) else begin
      miscompares++;
      $error("FAIL frames_sent_w2 cyc=%0d observed=%0d expected=%0d", c, frames_sent2, 2'(fr_exp));
    end
    vectors++;
    assert (tx2 === exp_tx[c]) else begin
      miscompares++;
      $error("FAIL tx_w2 cyc=%0d observed=%b expected=%b", c, tx2, exp_tx[c]);
    end
  endtask

  task automatic tick();
    bit rst_edge;
    bit acc;
    logic [AW-1:0] a;
    logic [OW-1:0] o;
    logic [DW-1:0] d;
    rst_edge = rst;
    acc = in_valid & ~rst & ~exp_hold[cyc];
    a = in_address; o = in_opcode; d = in_data;
    @(posedge clk);
    cyc++;
    if (rst_edge) begin
      model_reset(cyc);
      fr_exp = 0;
      checking = 1'b1;
    end else begin
      if (acc) model_accept(cyc, a, o, d);
      if (exp_inc[cyc]) fr_exp++;
    end
    @(negedge clk);
    if (checking) check(cyc);
  endtask

  // Presents junk while the model says the holding register is full, so a DUT
  // that samples fields without a handshake is caught; leaves in_valid high.
  task automatic send(input logic [AW-1:0] a, input logic [OW-1:0] o, input logic [DW-1:0] d);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    for (int n = 0; n < 400 && !done; n++) begin
      if (!rst && !exp_hold[cyc]) begin
        in_address = a; in_opcode = o; in_data = d;
        done = 1'b1;
      end else begin
        in_address = AW'($urandom); in_opcode = OW'($urandom);
        in_data = DW'({$urandom, $urandom});
      end
      tick();
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $error("FAIL send_timeout observed=not_accepted expected=accepted");
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic drain();
    in_valid = 1'b0;
    while (cyc < next_free + 3) tick();
  endtask

  int s_a;

  initial begin
    model_reset(0);
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(2);

    send(8'hAA, 3'h4, 62'd100);
    drain();

    send(8'h00, 3'h1, 62'h3FFF_FFFF_FFFF_FFFF);
    send(8'hFF, 3'h2, 62'd0);
    send(8'hAA, 3'h3, 62'h2AAA_AAAA_AAAA_AAAA);
    drain();

    send(8'h00, 3'h7, 62'h3FFF_FFFF_FFFF_FFFF);
    drain();

    send(8'h5C, 3'h5, 62'h1234_5678_9ABC_DEF0);
    s_a = last_s;
    send(8'hC3, 3'h6, 62'h0F0F_0F0F_0F0F_0F0F);
    in_valid = 1'b0;
    while (cyc < s_a + 40) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle(2);

    send(8'h11, 3'h1, 62'h2AAA_AAAA_AAAA_AAAA);
    drain();

    for (int i = 0; i < 7; i++) begin
      send(AW'($urandom), OW'($urandom), DW'({$urandom, $urandom}));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 90));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
